// File: rtl/mult_sequencer.sv
// Shift-add 64x64 -> 128 unsigned multiplier controller. It has no adder of its own:
// it drives the shared ripple-carry adder through ADD_* once per RUN cycle.
module mult_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     MCAND,
    input  logic [WIDTH-1:0]     MPLIER,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic [WIDTH-1:0]     ADD_A,
    output logic [WIDTH-1:0]     ADD_B,
    output logic                 ADD_C0,
    input  logic [WIDTH-1:0]     ADD_S,
    input  logic                 ADD_C64
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   hi, lo, mc;
    logic [CNT_W-1:0]   cnt;
    logic               last;

    assign last = (cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The adder carry-out is shifted into HI, so no sum bit is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi  <= '0;
            lo  <= '0;
            mc  <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mc  <= MCAND;
                    lo  <= MPLIER;
                    hi  <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    hi  <= {ADD_C64, ADD_S[WIDTH-1:1]};
                    lo  <= {ADD_S[0], lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outside RUN the shared adder sees a quiet 0 + 0.
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign ADD_A   = busy ? hi : '0;
    assign ADD_B   = (busy && lo[0]) ? mc : '0;
    assign ADD_C0  = 1'b0;
    assign PRODUCT = {hi, lo};

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed + random bench for mult_sequencer; models the shared adder and a
// cycle-level reference of the shift-add sequence.
module tb_mult_sequencer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  MCAND = '0, MPLIER = '0;
    logic         busy, done, ADD_C0, ADD_C64;
    logic [127:0] PRODUCT;
    logic [63:0]  ADD_A, ADD_B, ADD_S;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // shared 64-bit adder
    assign {ADD_C64, ADD_S} = {1'b0, ADD_A} + {1'b0, ADD_B} + {64'b0, ADD_C0};

    mult_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .MCAND(MCAND), .MPLIER(MPLIER),
        .busy(busy), .done(done), .PRODUCT(PRODUCT),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_C0(ADD_C0),
        .ADD_S(ADD_S), .ADD_C64(ADD_C64)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_ports(input string tag);
        chk({tag, "_a"},  128'(ADD_A),  128'(0));
        chk({tag, "_b"},  128'(ADD_B),  128'(0));
        chk({tag, "_c0"}, 128'(ADD_C0), 128'(0));
    endtask

    // Full multiply with per-cycle adder-port checks; returns in the IDLE cycle after DONE.
    task automatic mul(input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  hm, lm, eb;
        logic [64:0]  s;
        logic [127:0] exp;
        exp = {64'b0, a} * {64'b0, b};
        MCAND = a; MPLIER = b; start = 1'b1;
        step();
        start = 1'b0; MCAND = ~a; MPLIER = ~b;
        hm = '0; lm = b;
        for (int i = 0; i < 64; i++) begin
            eb = lm[0] ? a : 64'b0;
            chk("run_busy", 128'(busy),   128'(1));
            chk("run_done", 128'(done),   128'(0));
            chk("run_a",    128'(ADD_A),  128'(hm));
            chk("run_b",    128'(ADD_B),  128'(eb));
            chk("run_c0",   128'(ADD_C0), 128'(0));
            s  = {1'b0, hm} + {1'b0, eb};
            hm = s[64:1];
            lm = {s[0], lm[63:1]};
            step();
        end
        chk("done_pulse", 128'(done), 128'(1));
        chk("done_busy",  128'(busy), 128'(0));
        chk("product",    PRODUCT,    exp);
        quiet_ports("done");
        step();
        chk("idle_done", 128'(done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_prod", PRODUCT,    exp);
    endtask

    initial begin
        logic saw;
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_prod", PRODUCT,    128'(0));
        quiet_ports("rst");
        step(); step();
        reset = 1'b0;
        step();

        // 3 x 5, then hold through 10 idle cycles with junk on the operand inputs
        mul(64'd3, 64'd5);
        MCAND = 64'hDEAD_BEEF_0000_1111; MPLIER = 64'h5555_AAAA_5555_AAAA;
        for (int i = 0; i < 10; i++) begin
            chk("hold_prod", PRODUCT,    128'd15);
            chk("hold_busy", 128'(busy), 128'(0));
            quiet_ports("hold");
            step();
        end

        mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("max_prod", PRODUCT, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        mul(64'h1234_5678_9ABC_DEF0, 64'd0);
        chk("zero_prod", PRODUCT, 128'd0);
        mul(64'h1234_5678_9ABC_DEF0, 64'd1);
        chk("one_prod", PRODUCT, 128'h0000_0000_0000_0000_1234_5678_9ABC_DEF0);

        // start held high; operand change while busy must not matter
        MCAND = 64'd7; MPLIER = 64'd9; start = 1'b1;
        step();
        MCAND = 64'd2; MPLIER = 64'd2;
        for (int i = 0; i < 64; i++) begin
            chk("held_busy", 128'(busy), 128'(1));
            chk("held_done", 128'(done), 128'(0));
            step();
        end
        chk("held_done1", 128'(done), 128'(1));
        chk("held_p63",   PRODUCT,    128'd63);
        step();
        chk("held_idle",  128'(busy), 128'(0));
        chk("held_p63b",  PRODUCT,    128'd63);
        step();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("held2_busy", 128'(busy), 128'(1));
            step();
        end
        chk("held2_done", 128'(done), 128'(1));
        chk("held_p4",    PRODUCT,    128'd4);
        step();

        // async reset at RUN cycle 30
        MCAND = 64'd123; MPLIER = 64'd456; start = 1'b1;
        step();
        start = 1'b0;
        repeat (29) step();
        chk("pre_rst_busy", 128'(busy), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        chk("arst_prod", PRODUCT,    128'(0));
        quiet_ports("arst");
        step(); step();
        reset = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (done || busy) saw = 1'b1;
        end
        chk("arst_quiet", 128'(saw), 128'(0));
        mul(64'd6, 64'd7);
        chk("after_rst_42", PRODUCT, 128'd42);

        for (int i = 0; i < 200; i++)
            mul({$urandom, $urandom}, {$urandom, $urandom});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
